// File: rtl/reg_file_reader_pkg.sv
// Shared decode definitions for the vector register file read sequencer.
// Default geometry, element-index width and sequencer state encodings.
package reg_file_reader_pkg;

  localparam int unsigned DefWidthAddr   = 4;
  localparam int unsigned DefWidthVector = 8;
  localparam int unsigned DefN           = 32;
  localparam int unsigned ELEM_W         = $clog2(DefWidthVector);

  typedef logic [DefWidthVector-1:0][DefN-1:0] vec_t;

  // Plain constants rather than an enum so legacy tools can consume the encoding.
  typedef logic [2:0] rfr_state_e;
  localparam rfr_state_e StIdle   = 3'd0;
  localparam rfr_state_e StRead   = 3'd1;
  localparam rfr_state_e StCapt   = 3'd2;
  localparam rfr_state_e StStream = 3'd3;
  localparam rfr_state_e StFin    = 3'd4;

endpackage

// File: rtl/reg_file_reader.sv
// Reads COUNT consecutive register file entries from BASE and serialises each
// entry into N-bit elements on a valid/ready stream, flagging the final element.
module reg_file_reader
  import reg_file_reader_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR   = DefWidthAddr,
  parameter int unsigned WIDTH_VECTOR = DefWidthVector,
  parameter int unsigned N            = DefN
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [WIDTH_ADDR-1:0]           base,
  input  logic [WIDTH_ADDR:0]             count,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [WIDTH_ADDR-1:0]           rd_addr,
  input  logic [WIDTH_VECTOR*N-1:0]       rd_data,
  output logic [N-1:0]                    m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last,
  output logic [$clog2(WIDTH_VECTOR)-1:0] m_elem
);

  localparam int unsigned EW = $clog2(WIDTH_VECTOR);
  localparam logic [EW-1:0] LastElem = EW'(WIDTH_VECTOR - 1);
  localparam logic [WIDTH_ADDR:0] RemOne = (WIDTH_ADDR + 1)'(1);

  rfr_state_e                  state_q, state_d;
  logic [WIDTH_ADDR-1:0]       addr_q, addr_d;
  logic [WIDTH_ADDR:0]         remaining_q, remaining_d;
  logic [EW-1:0]               elem_q, elem_d;
  logic [WIDTH_VECTOR*N-1:0]   hold_q, hold_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    elem_d      = elem_q;
    hold_d      = hold_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base;
          remaining_d = count;
          state_d     = (count == '0) ? StFin : StRead;
        end
      end
      StRead: state_d = StCapt;
      StCapt: begin
        // Read data is valid here, one cycle after rd_en.
        hold_d  = rd_data;
        elem_d  = '0;
        state_d = StStream;
      end
      StStream: begin
        if (m_ready) begin
          if (elem_q != LastElem) begin
            elem_d = elem_q + EW'(1);
          end else begin
            remaining_d = remaining_q - RemOne;
            addr_d      = addr_q + WIDTH_ADDR'(1);
            state_d     = (remaining_q == RemOne) ? StFin : StRead;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      elem_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      elem_q      <= elem_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StFin);
    rd_en   = (state_q == StRead);
    rd_addr = addr_q;
    m_valid = (state_q == StStream);
    m_last  = m_valid && (elem_q == LastElem) && (remaining_q == RemOne);
    m_elem  = elem_q;
    m_data  = hold_q[elem_q*N +: N];
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader with a behavioural register file and
// stream monitor; each task drives one scenario and checks it inline.
module tb_reg_file_reader;
  import reg_file_reader_pkg::*;

  typedef struct packed {
    logic [ELEM_W-1:0] elem;
    logic [31:0]       data;
    logic              last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  base;
  logic [4:0]  count;
  logic        busy, done, rd_en, m_valid, m_ready, m_last;
  logic [3:0]  rd_addr;
  vec_t        rd_data;
  logic [31:0] m_data;
  logic [2:0]  m_elem;

  int n_cmp = 0;
  int n_err = 0;

  vec_t  mem [16];
  beat_t beats[$];
  beat_t exp_q[$];
  logic [3:0] addrs[$];
  int done_cnt = 0;

  always #5 clk = ~clk;

  reg_file_reader dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .base    (base),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_elem  (m_elem)
  );

  // Synchronous-read register file model.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) beats.push_back(beat_t'({m_elem, m_data, m_last}));
      if (rd_en) addrs.push_back(rd_addr);
      if (done) done_cnt++;
    end
  end

  function automatic logic [31:0] exp_data(input int a, input int e);
    return {8'(a), 8'(e), 16'hA5A5};
  endfunction

  task automatic build_exp(input int b, input int c);
    exp_q.delete();
    for (int k = 0; k < c; k++)
      for (int e = 0; e < 8; e++)
        exp_q.push_back(beat_t'({3'(e), exp_data((b + k) % 16, e), 1'((k == c - 1) && (e == 7))}));
  endtask

  task automatic clear_mon();
    beats.delete();
    addrs.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [3:0] b, input logic [4:0] c);
    @(negedge clk);
    start = 1'b1;
    base  = b;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    base = '0;
    count = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, rd_en, m_valid, m_last} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rd_en, m_valid, m_last});
    end
    n_cmp++;
    if (rd_addr !== 4'd0) begin
      n_err++;
      $display("FAIL reset_rd_addr: got %0d want 0", rd_addr);
    end
    n_cmp++;
    if (m_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_m_data: got %h want 0", m_data);
    end
    n_cmp++;
    if (m_elem !== 3'd0) begin
      n_err++;
      $display("FAIL reset_m_elem: got %0d want 0", m_elem);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    clear_mon();
    m_ready = 1'b1;
    pulse_start(4'd2, 5'd3);
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== 4'd2) begin
      n_err++;
      $display("FAIL basic_first_read: got en=%b addr=%0d want en=1 addr=2", rd_en, rd_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_capt_valid: got %b want 0", m_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== exp_data(2, 0)) begin
      n_err++;
      $display("FAIL basic_first_beat: got v=%b d=%h want v=1 d=%h", m_valid, m_data,
               exp_data(2, 0));
    end
    wait_done(200, ok, cyc);
    n_cmp++;
    if (!ok || cyc != 28) begin
      n_err++;
      $display("FAIL basic_done_time: got ok=%0d cycles=%0d want ok=1 cycles=28", ok, cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (2) @(negedge clk);
    build_exp(2, 3);
    n_cmp++;
    if (beats.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL basic_beat_count: got %0d want %0d", beats.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_beat[%0d]: got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (addrs.size() != 3 || addrs[0] !== 4'd2 || addrs[1] !== 4'd3 || addrs[2] !== 4'd4) begin
      n_err++;
      $display("FAIL basic_rd_addrs: got %p want 2 3 4", addrs);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL basic_done_count: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    logic [3:0] want;
    clear_mon();
    m_ready = 1'b1;
    pulse_start(4'd14, 5'd4);
    wait_done(300, ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL wrap_timeout: got no done want done");
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (addrs.size() != 4) begin
      n_err++;
      $display("FAIL wrap_read_count: got %0d want 4", addrs.size());
    end
    for (int k = 0; k < 4 && k < addrs.size(); k++) begin
      want = 4'(14 + k);
      n_cmp++;
      if (addrs[k] !== want) begin
        n_err++;
        $display("FAIL wrap_rd_addr[%0d]: got %0d want %0d", k, addrs[k], want);
      end
    end
    build_exp(14, 4);
    n_cmp++;
    if (beats.size() != 32) begin
      n_err++;
      $display("FAIL wrap_beat_count: got %0d want 32", beats.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL wrap_beat[%0d]: got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL wrap_done_count: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_count_zero();
    clear_mon();
    m_ready = 1'b1;
    pulse_start(4'd9, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done_t1: got done=%b busy=%b want 1 1", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done_t2: got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (addrs.size() != 0 || beats.size() != 0 || done_cnt != 1) begin
      n_err++;
      $display("FAIL zero_activity: got reads=%0d beats=%0d dones=%0d want 0 0 1",
               addrs.size(), beats.size(), done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stalls;
    logic pv, pr, pl;
    logic [31:0] pd;
    logic [2:0] pe;
    clear_mon();
    m_ready = 1'b0;
    pulse_start(4'd5, 5'd2);
    ok = 1'b0;
    stalls = 0;
    pv = 1'b0;
    pr = 1'b0;
    pl = 1'b0;
    pd = '0;
    pe = '0;
    for (int c = 0; c < 400; c++) begin
      if (pv && !pr) begin
        stalls++;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== pd || m_elem !== pe || m_last !== pl) begin
          n_err++;
          $display("FAIL bp_hold: got v=%b d=%h e=%0d l=%b want v=1 d=%h e=%0d l=%b",
                   m_valid, m_data, m_elem, m_last, pd, pe, pl);
        end
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
      m_ready = ($urandom_range(0, 9) < 3);
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pe = m_elem;
      pl = m_last;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok || stalls == 0) begin
      n_err++;
      $display("FAIL bp_progress: got done=%0d stalls=%0d want done=1 stalls>0", ok, stalls);
    end
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    build_exp(5, 2);
    n_cmp++;
    if (beats.size() != 16) begin
      n_err++;
      $display("FAIL bp_beat_count: got %0d want 16", beats.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_beat[%0d]: got %h want %h", i, beats[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    clear_mon();
    m_ready = 1'b1;
    pulse_start(4'd0, 5'd2);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (beats.size() == 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rstmid_reach: got %0d beats want 3", beats.size());
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_idle: got v=%b busy=%b rd_en=%b want 0 0 0", m_valid, busy, rd_en);
    end
    reset = 1'b0;
    clear_mon();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (beats.size() != 0 || addrs.size() != 0 || done_cnt != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet: got beats=%0d reads=%0d dones=%0d want 0 0 0",
               beats.size(), addrs.size(), done_cnt);
    end
    pulse_start(4'd0, 5'd1);
    wait_done(100, ok, cyc);
    repeat (3) @(negedge clk);
    build_exp(0, 1);
    n_cmp++;
    if (!ok || beats.size() != 8 || done_cnt != 1) begin
      n_err++;
      $display("FAIL rstmid_restart: got done=%0d beats=%0d dones=%0d want 1 8 1",
               ok, beats.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rstmid_beat[%0d]: got %h want %h", i, beats[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    int cyc;
    int bad;
    clear_mon();
    m_ready = 1'b1;
    pulse_start(4'd0, 5'd16);
    repeat (20) @(negedge clk);
    start = 1'b1;
    base  = 4'd7;
    count = 5'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, ok, cyc);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || done_cnt != 1) begin
      n_err++;
      $display("FAIL busy_done: got done=%0d dones=%0d want 1 1", ok, done_cnt);
    end
    n_cmp++;
    if (beats.size() != 128 || addrs.size() != 16) begin
      n_err++;
      $display("FAIL busy_counts: got beats=%0d reads=%0d want 128 16", beats.size(),
               addrs.size());
    end
    build_exp(0, 16);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      if (beats[i] !== exp_q[i]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL busy_beats: got %0d wrong beats want 0", bad);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++)
      for (int e = 0; e < 8; e++)
        mem[a][e] = exp_data(a, e);
    test_reset();
    test_basic();
    test_wrap();
    test_count_zero();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
